// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory image loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_LO = 3'd1,
    HDR_HI = 3'd2,
    WORD   = 3'd3,
    PAD    = 3'd4,
    CHECK  = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } loader_state_e;

  // addi x0,x0,0 -- fills the unused bank B slot of an odd-length image
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
  localparam int unsigned HDR_BYTES = 2;

endpackage

// File: rtl/byte_packer.sv
// Little-endian 8-to-32 assembler: four accepted bytes form one word, LSB first.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q;
  logic [23:0] sr_q;

  // The 4th byte completes the word combinationally so the parent can register it.
  assign word_valid_o = byte_en_i && (cnt_q == 2'd3);
  assign word_o       = {byte_i, sr_q};

  // Byte counter and shift register; earlier bytes slide toward the LSB end.
  always_ff @(posedge clk) begin
    if (!rst || clear_i) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (byte_en_i) begin
      cnt_q <= cnt_q + 2'd1;
      sr_q  <= {byte_i, sr_q[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream image loader for the dual-bank instruction memory.
// Even word indices go to bank A, odd to bank B; the core is held in reset
// until a complete image with a matching XOR checksum has been written.
module imem_loader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] NOP_WORD   = loader_pkg::NOP_WORD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  we_a,
  output logic                  we_b,
  output logic [ADDR_WIDTH-2:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  core_hold,
  output logic                  done,
  output logic                  error
);

  import loader_pkg::*;

  localparam int unsigned CAPACITY = 1 << ADDR_WIDTH;

  loader_state_e         state_q, state_d;
  logic [15:0]           n_q, n_d;
  logic [ADDR_WIDTH:0]   widx_q, widx_d;
  logic [7:0]            chk_q, chk_d;
  logic                  ready_q, ready_d;
  logic                  we_a_q, we_a_d, we_b_q, we_b_d;
  logic [ADDR_WIDTH-2:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  done_q, error_q, hold_q;
  logic                  xfer, clr;
  logic                  word_valid;
  logic [31:0]           word;
  logic [15:0]           n_full;

  assign xfer   = byte_valid && ready_q;
  assign n_full = {byte_data, n_q[7:0]};

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clr),
    .byte_en_i    (xfer && (state_q == WORD)),
    .byte_i       (byte_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // Next-state, bank-select and write-port decode.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    widx_d  = widx_q;
    chk_d   = xfer ? (chk_q ^ byte_data) : chk_q;
    clr     = 1'b0;
    we_a_d  = 1'b0;
    we_b_d  = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (load_start) begin
          state_d = HDR_LO;
          clr     = 1'b1;
          chk_d   = '0;
          widx_d  = '0;
        end
      end
      HDR_LO: begin
        if (xfer) begin
          n_d     = {8'h00, byte_data};
          state_d = HDR_HI;
        end
      end
      HDR_HI: begin
        if (xfer) begin
          n_d = n_full;
          if (32'(n_full) > CAPACITY) state_d = ERR;
          else if (n_full == 16'd0)   state_d = CHECK;
          else                        state_d = WORD;
        end
      end
      WORD: begin
        if (word_valid) begin
          we_a_d  = ~widx_q[0];
          we_b_d  = widx_q[0];
          waddr_d = (ADDR_WIDTH-1)'(widx_q >> 1);
          wdata_d = DATA_WIDTH'(word);
          widx_d  = widx_q + 1'b1;
          if (32'(widx_q) == 32'(n_q) - 32'd1) state_d = n_q[0] ? PAD : CHECK;
        end
      end
      PAD: begin
        we_b_d  = 1'b1;
        waddr_d = (ADDR_WIDTH-1)'((n_q - 16'd1) >> 1);
        wdata_d = DATA_WIDTH'(NOP_WORD);
        state_d = CHECK;
      end
      CHECK: begin
        if (xfer) state_d = (byte_data == chk_q) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are registered.
  always_comb begin
    ready_d = (state_d == HDR_LO) || (state_d == HDR_HI) ||
              (state_d == WORD)   || (state_d == CHECK);
  end

  // State, datapath and registered output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      widx_q  <= '0;
      chk_q   <= '0;
      ready_q <= 1'b0;
      we_a_q  <= 1'b0;
      we_b_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      widx_q  <= widx_d;
      chk_q   <= chk_d;
      ready_q <= ready_d;
      we_a_q  <= we_a_d;
      we_b_q  <= we_b_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= (state_d == DONE);
      error_q <= (state_d == ERR);
      hold_q  <= (state_d != DONE);
    end
  end

  assign byte_ready = ready_q;
  assign we_a       = we_a_q;
  assign we_b       = we_b_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign done       = done_q;
  assign error      = error_q;
  assign core_hold  = hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader.
module tb_imem_loader;

  localparam int AW = 12;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          we_a, we_b;
  logic [AW-2:0] waddr;
  logic [31:0]   wdata;
  logic          core_hold, done, error;

  imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .NOP_WORD(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .we_a(we_a), .we_b(we_b),
    .waddr(waddr), .wdata(wdata), .core_hold(core_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          bank;
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img[CAP];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the next expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && (we_a || we_b)) begin
        wr_t e;
        chk("single_bank_strobe", {31'd0, we_a && we_b}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=a%0d/b%0d@%0d:%h expected=none",
                   we_a, we_b, waddr, wdata);
        end else begin
          e = exp_q.pop_front();
          chk("write_bank", {31'd0, we_b}, {31'd0, e.bank});
          chk("write_addr", 32'(waddr), 32'(e.addr));
          chk("write_data", wdata, e.data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (!byte_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout actual=ready0 expected=ready1");
    end
  endtask

  task automatic end_stream();
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  // Optionally holds a junk byte valid while the loader is not ready.
  task automatic start_load(input bit junk);
    @(negedge clk);
    if (junk) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      repeat (2) @(negedge clk);
    end
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    byte_valid = 1'b0;
    chk("start_ready", {31'd0, byte_ready}, 32'd1);
    chk("start_done", {31'd0, done}, 32'd0);
    chk("start_error", {31'd0, error}, 32'd0);
    chk("start_hold", {31'd0, core_hold}, 32'd1);
  endtask

  // Reference: stream = N header, LE words, XOR checksum; writes = word i to
  // bank i%2 at i/2, plus a NOP into bank B when N is odd.
  task automatic do_load(input int n, input bit corrupt, input int maxgap, input bit junk);
    logic [7:0] s[$];
    logic [7:0] x;
    bit         ok;
    int         t;
    s.push_back(8'(n));
    s.push_back(8'(n >> 8));
    if (n <= CAP) begin
      for (int i = 0; i < n; i++) begin
        for (int j = 0; j < 4; j++) s.push_back(8'(img[i] >> (8 * j)));
        exp_q.push_back('{bank: bit'(i % 2), addr: i / 2, data: img[i]});
      end
      if (n % 2 == 1) exp_q.push_back('{bank: 1'b1, addr: (n - 1) / 2, data: 32'h0000_0013});
      x = 8'h00;
      foreach (s[i]) x = x ^ s[i];
      s.push_back(corrupt ? (x ^ 8'h01) : x);
      ok = !corrupt;
    end else begin
      ok = 1'b0;
    end
    start_load(junk);
    foreach (s[i]) send_byte(s[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end_stream();
    t = 0;
    while (!(done || error) && t < 40) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk("end_done", {31'd0, done}, {31'd0, ok});
    chk("end_error", {31'd0, error}, {31'd0, !ok});
    chk("end_hold", {31'd0, core_hold}, {31'd0, !ok});
    chk("end_ready", {31'd0, byte_ready}, 32'd0);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    rst        = 1'b0;
    load_start = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_we", {30'd0, we_a, we_b}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_hold", {31'd0, core_hold}, 32'd1);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    rst = 1'b1;

    img[0] = 32'h0050_0093;
    img[1] = 32'h00A0_0113;
    img[2] = 32'h0000_0073;
    do_load(2, 1'b0, 0, 1'b0);
    do_load(3, 1'b0, 0, 1'b0);
    do_load(2, 1'b1, 0, 1'b0);
    do_load(4097, 1'b0, 0, 1'b0);
    do_load(2, 1'b0, 3, 1'b1);
    do_load(3, 1'b0, 3, 1'b1);

    for (int k = 0; k < 8; k++) begin
      n = int'($urandom_range(0, 12));
      for (int i = 0; i < n; i++) img[i] = $urandom;
      do_load(n, ($urandom % 4) == 0, 3, ($urandom % 2) == 1);
    end

    // Abort mid-load: header N=2 plus two word bytes, then reset.
    start_load(1'b0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h93, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    byte_valid = 1'b0;
    rst        = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_ready", {31'd0, byte_ready}, 32'd0);
    chk("abort_hold", {31'd0, core_hold}, 32'd1);
    chk("abort_done", {31'd0, done}, 32'd0);
    do_load(0, 1'b0, 0, 1'b0);

    // Full capacity must not wrap the word index.
    for (int i = 0; i < CAP; i++) img[i] = $urandom;
    do_load(CAP, 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
